mult_seq_ctrl: RTL and testbench

Multi-cycle sequencer that computes a full 32x32 -> 64-bit product (MULT/MULTU) by time-sharing one 16x16 -> 32-bit multiplier array over four partial-product cycles. It sits beside the ALU in the execute stage and owns the architectural HI/LO registers. It serves MTHI/MTLO writes and reports ready/busy to the pipeline stall logic.

---
 rtl/mult_pkg.sv | 18 +
 rtl/multN.sv | 14 +
 rtl/mult_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and partial-product constants for mult_seq_ctrl
package mult_pkg;

   localparam int MULT_W    = 32;
   localparam int HALF      = MULT_W / 2;
   localparam int SHIFT_MID = HALF;
   localparam int SHIFT_HI  = MULT_W;

   typedef enum logic [2:0] {
      IDLE,
      PP0,
      PP1,
      PP2,
      PP3,
      FIX
   } state_t;

endpackage

// File: rtl/multN.sv
// rtl/multN.sv - unsigned (N/2)x(N/2) -> N combinational multiplier array
module multN #(
   parameter int N = 32
) (
   input  logic [N/2-1:0] a,
   input  logic [N/2-1:0] b,
   output logic [N-1:0]   p
);

   localparam int H = N / 2;

   assign p = {{H{1'b0}}, a} * {{H{1'b0}}, b};

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - MULT/MULTU sequencer over one shared half-width array; owns HI/LO
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int N = MULT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         is_signed,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   input  logic         mt_en,
   input  logic         mt_sel,
   input  logic [N-1:0] mt_data,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam int H = N / 2;
   localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

   state_t         state;
   logic [H-1:0]   a_hi, a_lo, b_hi, b_lo;
   logic           neg;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] pp;
   logic [2*N-1:0] fixed;
   logic [H-1:0]   m_a, m_b;
   logic [N-1:0]   m_p;

   // -2^(N-1) maps to 2^(N-1), which still fits an unsigned N-bit value
   function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic sgn);
      return (sgn && x[N-1]) ? (~x + ONE_N) : x;
   endfunction

   always_comb begin
      m_a = '0;
      m_b = '0;
      case (state)
         PP0: begin m_a = a_lo; m_b = b_lo; end
         PP1: begin m_a = a_lo; m_b = b_hi; end
         PP2: begin m_a = a_hi; m_b = b_lo; end
         PP3: begin m_a = a_hi; m_b = b_hi; end
         default: ;
      endcase
   end

   multN #(.N(N)) u_mult (
      .a (m_a),
      .b (m_b),
      .p (m_p)
   );

   assign pp    = {{N{1'b0}}, m_p};
   assign fixed = neg ? (~acc + ONE_2N) : acc;
   assign busy  = ~ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_hi  <= '0;
         a_lo  <= '0;
         b_hi  <= '0;
         b_lo  <= '0;
         neg   <= 1'b0;
         acc   <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
         ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // start has priority; a simultaneous mt write is dropped
               if (start) begin
                  {a_hi, a_lo} <= mag(op_a, is_signed);
                  {b_hi, b_lo} <= mag(op_b, is_signed);
                  neg          <= is_signed & (op_a[N-1] ^ op_b[N-1]);
                  acc          <= '0;
                  ready        <= 1'b0;
                  state        <= PP0;
               end else if (mt_en) begin
                  if (mt_sel) hi <= mt_data;
                  else        lo <= mt_data;
               end
            end
            PP0: begin
               acc   <= acc + pp;
               state <= PP1;
            end
            PP1: begin
               acc   <= acc + (pp << SHIFT_MID);
               state <= PP2;
            end
            PP2: begin
               acc   <= acc + (pp << SHIFT_MID);
               state <= PP3;
            end
            PP3: begin
               acc   <= acc + (pp << SHIFT_HI);
               state <= FIX;
            end
            FIX: begin
               hi    <= fixed[2*N-1:N];
               lo    <= fixed[N-1:0];
               done  <= 1'b1;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - randomized and directed self-checking bench for mult_seq_ctrl
module tb_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        mt_en = 1'b0;
   logic        mt_sel = 1'b0;
   logic [31:0] mt_data = '0;
   logic        ready, busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   mult_seq_ctrl #(.N(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .mt_en     (mt_en),
      .mt_sel    (mt_sel),
      .mt_data   (mt_data),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Behavioural model: a countdown of remaining busy cycles and the pending product
   int          e_cnt = 0;
   logic [63:0] e_prod = '0;
   logic [31:0] e_hi = '0;
   logic [31:0] e_lo = '0;
   logic        e_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_cnt  <= 0;
         e_hi   <= '0;
         e_lo   <= '0;
         e_done <= 1'b0;
      end else begin
         e_done <= 1'b0;
         if (e_cnt == 0) begin
            if (start) begin
               e_cnt  <= 5;
               e_prod <= ref_prod(op_a, op_b, is_signed);
            end else if (mt_en) begin
               if (mt_sel) e_hi <= mt_data;
               else        e_lo <= mt_data;
            end
         end else if (e_cnt == 1) begin
            e_cnt  <= 0;
            e_hi   <= e_prod[63:32];
            e_lo   <= e_prod[31:0];
            e_done <= 1'b1;
         end else begin
            e_cnt <= e_cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_ready", 64'(ready), 64'(e_cnt == 0));
         check("cyc_busy",  64'(busy),  64'(e_cnt != 0));
         check("cyc_done",  64'(done),  64'(e_done));
         check("cyc_hi",    64'(hi),    64'(e_hi));
         check("cyc_lo",    64'(lo),    64'(e_lo));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      op_a = a; op_b = b; is_signed = s; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (!done && k < 20) begin
         tick();
         k++;
      end
   endtask

   task automatic mult_lit(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eh, input logic [31:0] el);
      int k;
      launch(a, b, s);
      wait_done(k);
      check({nm, "_lat"}, 64'(k), 64'd5);
      check({nm, "_hi"}, 64'(hi), 64'(eh));
      check({nm, "_lo"}, 64'(lo), 64'(el));
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int dn;
      logic [31:0] got_hi, got_lo;

      tick();
      tick();
      chk_en = 1'b1;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      tick();

      mult_lit("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
      mult_lit("mult_m3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      mult_lit("mult_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
      mult_lit("mult_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
      mult_lit("multu_min2", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000);

      // start pulsed during PP2 must be ignored
      launch(32'h0001_2345, 32'h0001_0000, 1'b0);
      tick();
      tick();
      op_a = 32'h3; op_b = 32'h3; start = 1'b1;
      tick();
      start = 1'b0;
      dn = 0; got_hi = '0; got_lo = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) begin
            dn++;
            got_hi = hi;
            got_lo = lo;
         end
      end
      check("pp2_start_dones", 64'(dn), 64'd1);
      check("pp2_start_hi", 64'(got_hi), 64'h1);
      check("pp2_start_lo", 64'(got_lo), 64'h2345_0000);

      // mt_en during PP1 must be ignored
      launch(32'd7, 32'd6, 1'b0);
      tick();
      mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_0BAD;
      tick();
      mt_en = 1'b0;
      wait_done(k);
      check("mt_pp1_lo", 64'(lo), 64'd42);
      check("mt_pp1_hi", 64'(hi), 64'd0);
      tick();

      mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'h0000_1234;
      tick();
      mt_en = 1'b0;
      check("mthi_hi", 64'(hi), 64'h1234);
      check("mthi_lo", 64'(lo), 64'd42);

      // start and mt_en together: mt write is dropped
      op_a = 32'h0001_0000; op_b = 32'h0003_0000; is_signed = 1'b0; start = 1'b1;
      mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_DEAD;
      tick();
      start = 1'b0; mt_en = 1'b0;
      check("mt_drop_lo", 64'(lo), 64'd42);
      check("mt_drop_busy", 64'(busy), 64'd1);
      wait_done(k);
      check("both_hi", 64'(hi), 64'd3);
      check("both_lo", 64'(lo), 64'd0);
      tick();

      // reset during PP3 aborts with no done
      launch(32'd5, 32'd5, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_ready", 64'(ready), 64'd1);
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) dn++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) dn++;
      end
      check("abort_dones", 64'(dn), 64'd0);
      mult_lit("post_rst", 32'd7, 32'd6, 1'b0, 32'd0, 32'd42);

      for (int i = 0; i < 600; i++) begin
         start     = ($urandom_range(0, 2) == 0);
         is_signed = 1'($urandom_range(0, 1));
         op_a      = rnd_op();
         op_b      = rnd_op();
         mt_en     = ($urandom_range(0, 3) == 0);
         mt_sel    = 1'($urandom_range(0, 1));
         mt_data   = $urandom();
         rst_n     = ($urandom_range(0, 199) != 0);
         tick();
      end
      start = 1'b0; mt_en = 1'b0; rst_n = 1'b1;
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
